// File: rtl/lab7_soc_switch_pio_irq.sv
// Avalon-MM input PIO: synchronised (optionally debounced) input bus, sticky edge capture, maskable level irq.
// Latency: input to DATA/EDGE_CAP two cycles after s1 in bypass, three accepted ticks when debounced; read latency 1.
// Backpressure: none; slave always accepts, readdata is refreshed every cycle from the address bus.
module lab7_soc_switch_pio_irq #(
    parameter int WIDTH        = 20,
    parameter int EDGE_MODE    = 0,
    parameter int DEBOUNCE_DIV = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] cap_d;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [31:0]      rdata_q;
    logic [31:0]      rdata_d;
    logic [WIDTH-1:0] edge_vec;
    logic [WIDTH-1:0] clr;
    logic             wr_mask;
    logic             wr_cap;
    logic             unused_wdata;

    // Upper writedata bits are meaningless when WIDTH < 32.
    assign unused_wdata = ^writedata;

    // Two-flop synchroniser; the only path from in_port into the block.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= in_port;
            s2_q <= s2_next(s1_q);
        end
    end

    function automatic logic [WIDTH-1:0] s2_next(input logic [WIDTH-1:0] v);
        return v;
    endfunction

    generate
        if (DEBOUNCE_DIV == 0) begin : g_bypass
            assign data_d = s2_q;
        end else begin : g_debounce
            localparam int             PW   = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
            localparam logic [PW-1:0]  PMAX = PW'(DEBOUNCE_DIV - 1);

            logic [PW-1:0]    presc_q;
            logic [PW-1:0]    presc_d;
            logic             tick;
            logic [WIDTH-1:0] hist0_q;
            logic [WIDTH-1:0] hist0_d;
            logic [WIDTH-1:0] hist1_q;
            logic [WIDTH-1:0] hist1_d;
            logic [WIDTH-1:0] accept;

            // Prescaler tick and per-bit acceptance: a bit changes only when the two
            // previous tick samples and the current s2 all agree.
            always_comb begin
                tick    = (presc_q == PMAX);
                presc_d = tick ? '0 : presc_q + PW'(1);
                hist0_d = hist0_q;
                hist1_d = hist1_q;
                accept  = '0;
                if (tick) begin
                    hist0_d = s2_q;
                    hist1_d = hist0_q;
                    accept  = ~(hist1_q ^ hist0_q) & ~(hist0_q ^ s2_q);
                end
                data_d = (data_q & ~accept) | (s2_q & accept);
            end

            // Prescaler and tick history; reset discards any partial debounce.
            always_ff @(posedge clk) begin
                if (reset) begin
                    presc_q <= '0;
                    hist0_q <= '0;
                    hist1_q <= '0;
                end else begin
                    presc_q <= presc_d;
                    hist0_q <= hist0_d;
                    hist1_q <= hist1_d;
                end
            end
        end
    endgenerate

    // Edge detection against the accepted value, capture update, register writes, read mux.
    always_comb begin
        if (EDGE_MODE == 0) begin
            edge_vec = data_d & ~data_q;
        end else if (EDGE_MODE == 1) begin
            edge_vec = ~data_d & data_q;
        end else begin
            edge_vec = data_d ^ data_q;
        end
        wr_mask = chipselect && write && (address == 2'd1);
        wr_cap  = chipselect && write && (address == 2'd3);
        clr     = wr_cap ? writedata[WIDTH-1:0] : '0;
        // A new edge on a bit wins over a simultaneous write-1-to-clear.
        cap_d   = (cap_q & ~clr) | edge_vec;
        mask_d  = wr_mask ? writedata[WIDTH-1:0] : mask_q;
        case (address)
            2'd0:    rdata_d = 32'(data_q);
            2'd1:    rdata_d = 32'(mask_q);
            2'd3:    rdata_d = 32'(cap_q);
            default: rdata_d = '0;
        endcase
    end

    // Architectural registers and the registered read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            cap_q   <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
        end else begin
            data_q  <= data_d;
            cap_q   <= cap_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
        end
    end

    assign readdata = rdata_q;
    // Combinational from flops only, so no in_port glitch reaches the interrupt line.
    assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_lab7_soc_switch_pio_irq.sv
// Directed bench for the switch PIO: four instances share the Avalon bus and clock.
// A: rising/bypass, B: falling/bypass, C: any/bypass (B and C share one input), D: rising/DEBOUNCE_DIV=4.
// Every check goes through check_eq; expected values are hand-derived constants.
module tb_lab7_soc_switch_pio_irq;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic [19:0] in_a;
    logic [19:0] in_b;
    logic [19:0] in_d;
    logic [31:0] rd_a, rd_b, rd_c, rd_d;
    logic        irq_a, irq_b, irq_c, irq_d;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;

    always #5 clk = ~clk;

    lab7_soc_switch_pio_irq #(.WIDTH(20), .EDGE_MODE(0), .DEBOUNCE_DIV(0)) u_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
        .writedata(writedata), .readdata(rd_a), .in_port(in_a), .irq(irq_a));
    lab7_soc_switch_pio_irq #(.WIDTH(20), .EDGE_MODE(1), .DEBOUNCE_DIV(0)) u_b (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
        .writedata(writedata), .readdata(rd_b), .in_port(in_b), .irq(irq_b));
    lab7_soc_switch_pio_irq #(.WIDTH(20), .EDGE_MODE(2), .DEBOUNCE_DIV(0)) u_c (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
        .writedata(writedata), .readdata(rd_c), .in_port(in_b), .irq(irq_c));
    lab7_soc_switch_pio_irq #(.WIDTH(20), .EDGE_MODE(0), .DEBOUNCE_DIV(4)) u_d (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
        .writedata(writedata), .readdata(rd_d), .in_port(in_d), .irq(irq_d));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance n rising edges; inputs change and outputs are sampled 1ns after each edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write      = 1'b1;
        step(1);
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a);
        address = a;
        step(1);
    endtask

    // Edges (first = 1) until DATA bit 0 of instance D reads back as 1; 99 on timeout.
    task automatic wait_deb(output int n);
        n       = 99;
        address = 2'd0;
        for (int i = 1; i <= 30; i++) begin
            step(1);
            if (rd_d[0] === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; address = 2'd0; chipselect = 1'b0; write = 1'b0; writedata = '0;
        in_a = '0; in_b = '0; in_d = '0;
        step(3);
        check_eq("rst_rd_a", rd_a, 32'h0);
        check_eq("rst_irq_a", {31'b0, irq_a}, 32'h0);
        reset = 1'b0;

        // Every address reads zero out of reset.
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a));
            check_eq($sformatf("rst_addr%0d", a), rd_a, 32'h0);
        end
        check_eq("rst_irq_d", {31'b0, irq_d}, 32'h0);

        // Mask is WIDTH bits wide; reserved address ignores writes.
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_read(2'd1);
        check_eq("mask_width", rd_a, 32'h000F_FFFF);
        bus_write(2'd2, 32'hFFFF_FFFF);
        bus_read(2'd2);
        check_eq("reserved_rd", rd_a, 32'h0);

        // Bypass rising edges: capture and irq two edges after s1 samples the change.
        in_a = 20'h00005;
        step(1);
        check_eq("irq_k", {31'b0, irq_a}, 32'h0);
        step(1);
        check_eq("irq_k1", {31'b0, irq_a}, 32'h0);
        step(1);
        check_eq("irq_k2", {31'b0, irq_a}, 32'h1);
        bus_read(2'd3);
        check_eq("cap_5", rd_a, 32'h5);
        bus_read(2'd0);
        check_eq("data_5", rd_a, 32'h5);

        // Write-1-to-clear: partial clear keeps irq, full clear drops it.
        bus_write(2'd3, 32'h1);
        check_eq("irq_partial", {31'b0, irq_a}, 32'h1);
        bus_read(2'd3);
        check_eq("cap_4", rd_a, 32'h4);
        bus_write(2'd3, 32'h4);
        check_eq("irq_cleared", {31'b0, irq_a}, 32'h0);

        // Mask gating.
        bus_write(2'd1, 32'h0);
        in_a = 20'h0000D;
        step(3);
        check_eq("irq_masked", {31'b0, irq_a}, 32'h0);
        bus_read(2'd3);
        check_eq("cap_bit3", rd_a, 32'h8);
        bus_write(2'd1, 32'h8);
        check_eq("irq_unmasked", {31'b0, irq_a}, 32'h1);
        bus_write(2'd3, 32'hFFFFF);
        check_eq("irq_clr_all", {31'b0, irq_a}, 32'h0);

        // Edge modes: rising on B/C, then falling on A/B/C.
        in_b = 20'h1;
        step(3);
        bus_read(2'd3);
        check_eq("mode1_rise", rd_b, 32'h0);
        check_eq("mode2_rise", rd_c, 32'h1);
        bus_write(2'd3, 32'hFFFFF);
        in_b = 20'h0;
        in_a = 20'h0000C;
        step(3);
        bus_read(2'd3);
        check_eq("mode0_fall", rd_a, 32'h0);
        check_eq("mode1_fall", rd_b, 32'h1);
        check_eq("mode2_fall", rd_c, 32'h1);
        bus_write(2'd3, 32'hFFFFF);

        // Set beats clear: the clear write lands on the edge where bit 0 of A is captured.
        in_a = 20'h0000D;
        step(2);
        bus_write(2'd3, 32'h1);
        bus_read(2'd3);
        check_eq("set_wins", rd_a, 32'h1);

        // Debounce: a 6-cycle glitch spans at most two ticks and is rejected.
        in_d = 20'h1;
        step(6);
        in_d = 20'h0;
        step(20);
        bus_read(2'd0);
        check_eq("glitch_data", rd_d, 32'h0);
        bus_read(2'd3);
        check_eq("glitch_cap", rd_d, 32'h0);

        // Stable level: accepted on the third tick, read back one edge later.
        in_d = 20'h1;
        wait_deb(lat);
        check_eq("deb_lat_min", {31'b0, (lat >= 11)}, 32'h1);
        check_eq("deb_lat_max", {31'b0, (lat <= 14)}, 32'h1);
        bus_read(2'd3);
        check_eq("deb_cap", rd_d, 32'h1);

        // Reset in the middle of a debounce window.
        in_d = 20'h0;
        step(5);
        in_d  = 20'h1;
        reset = 1'b1;
        step(1);
        check_eq("mid_rst_rd_a", rd_a, 32'h0);
        check_eq("mid_rst_rd_b", rd_b, 32'h0);
        check_eq("mid_rst_rd_c", rd_c, 32'h0);
        check_eq("mid_rst_rd_d", rd_d, 32'h0);
        check_eq("mid_rst_irq", {28'b0, irq_a, irq_b, irq_c, irq_d}, 32'h0);
        reset = 1'b0;
        // Fresh prescaler: ticks at edges 4, 8, 12 after release, readback on edge 13.
        wait_deb(lat);
        check_eq("deb_restart_lat", 32'(lat), 32'd13);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
